// File: rtl/ncsim_uart_pkg.sv
// Shared UART definitions for the simulation injector (host-to-core) and the
// printf receiver (core-to-host).
//   UART_DATA_BITS  : data bits per 8N1 frame
//   UART_IDLE_LEVEL : line level while idle and during the stop bit
//   uart_tx_state_e : transmitter FSM states
package ncsim_uart_pkg;

    localparam int unsigned UART_DATA_BITS  = 8;
    localparam logic        UART_IDLE_LEVEL = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_e;

endpackage

// File: rtl/ncsim_uart_tx_fifo.sv
// Synchronous byte FIFO with first-word-fall-through read data.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_push       : write i_wdata (ignored when full)
//   i_pop        : drop head entry (ignored when empty)
//   i_flush      : empty the FIFO; wins over push and pop
//   o_rdata      : head entry, valid whenever !o_empty
//   o_full, o_empty, o_count : occupancy status
module ncsim_uart_tx_fifo
    import ncsim_uart_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = AW + 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_push,
    input  logic [UART_DATA_BITS-1:0] i_wdata,
    input  logic                      i_pop,
    input  logic                      i_flush,
    output logic [UART_DATA_BITS-1:0] o_rdata,
    output logic                      o_full,
    output logic                      o_empty,
    output logic [CW-1:0]             o_count
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("ncsim_uart_tx_fifo: DEPTH must be a power of 2 and >= 2");
    end

    logic [UART_DATA_BITS-1:0] r_mem [DEPTH];
    logic [AW-1:0]             r_wptr;
    logic [AW-1:0]             r_rptr;
    logic [CW-1:0]             r_count;
    logic                      w_push;
    logic                      w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge i_clk) begin
        if (w_push && !i_flush) r_mem[r_wptr] <= i_wdata;
    end

endmodule

// File: rtl/ncsim_uart_injector.sv
// UART 8N1 transmitter driving the SoC uart_rx pin (host-to-core direction).
// Bytes pushed on a valid/ready port are queued and sent LSB-first.
//   i_clk, i_rst     : clock, asynchronous active-high reset
//   i_push_valid/o_push_ready/i_push_data : byte input handshake
//   i_flush          : drop queued bytes; the frame in flight completes
//   o_uart_tx        : registered serial output, idles high
//   o_busy           : frame in flight or bytes queued
//   o_fifo_count     : queued bytes, excluding the one in flight
module ncsim_uart_injector
    import ncsim_uart_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 100000,
    parameter int unsigned UART_CLK_HZ = 1000,
    parameter int unsigned FIFO_DEPTH  = 16,
    localparam int unsigned CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_push_valid,
    input  logic [UART_DATA_BITS-1:0] i_push_data,
    output logic                      o_push_ready,
    input  logic                      i_flush,
    output logic                      o_uart_tx,
    output logic                      o_busy,
    output logic [CW-1:0]             o_fifo_count
);

    localparam int unsigned DIV = CLK_HZ / UART_CLK_HZ;
    localparam int unsigned BW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned IW  = $clog2(UART_DATA_BITS);

    if (DIV < 2) begin : g_div_check
        $error("ncsim_uart_injector: CLK_HZ/UART_CLK_HZ must be >= 2");
    end

    uart_tx_state_e            r_state, w_state_d;
    logic [BW-1:0]             r_bcnt, w_bcnt_d;
    logic [IW-1:0]             r_bidx, w_bidx_d;
    logic [UART_DATA_BITS-1:0] r_shreg, w_shreg_d;
    logic                      r_tx, w_tx_d;

    logic                      w_pop;
    logic                      w_can_pop;
    logic                      w_bit_end;
    logic [UART_DATA_BITS-1:0] w_fifo_rdata;
    logic                      w_fifo_full;
    logic                      w_fifo_empty;

    ncsim_uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (i_push_valid),
        .i_wdata (i_push_data),
        .i_pop   (w_pop),
        .i_flush (i_flush),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (o_fifo_count)
    );

    // Ready ignores a same-cycle pop so it never depends on the FSM.
    assign o_push_ready = ~w_fifo_full;
    assign o_busy       = (r_state != IDLE) | (o_fifo_count != '0);
    assign o_uart_tx    = r_tx;

    assign w_can_pop = ~w_fifo_empty & ~i_flush;
    assign w_bit_end = (r_bcnt == BW'(DIV - 1));

    always_comb begin
        w_state_d = r_state;
        w_bcnt_d  = r_bcnt;
        w_bidx_d  = r_bidx;
        w_shreg_d = r_shreg;
        w_pop     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_can_pop) begin
                    w_pop     = 1'b1;
                    w_shreg_d = w_fifo_rdata;
                    w_bcnt_d  = '0;
                    w_state_d = START;
                end
            end
            START: begin
                w_bcnt_d = r_bcnt + BW'(1);
                if (w_bit_end) begin
                    w_bcnt_d  = '0;
                    w_bidx_d  = '0;
                    w_state_d = DATA;
                end
            end
            DATA: begin
                w_bcnt_d = r_bcnt + BW'(1);
                if (w_bit_end) begin
                    w_bcnt_d  = '0;
                    w_shreg_d = {1'b0, r_shreg[UART_DATA_BITS-1:1]};
                    if (r_bidx == IW'(UART_DATA_BITS - 1)) begin
                        w_state_d = STOP;
                    end else begin
                        w_bidx_d = r_bidx + IW'(1);
                    end
                end
            end
            STOP: begin
                w_bcnt_d = r_bcnt + BW'(1);
                if (w_bit_end) begin
                    w_bcnt_d = '0;
                    // Chain straight into the next start bit: no idle gap.
                    if (w_can_pop) begin
                        w_pop     = 1'b1;
                        w_shreg_d = w_fifo_rdata;
                        w_state_d = START;
                    end else begin
                        w_state_d = IDLE;
                    end
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    // Line level follows the current state, one cycle behind it.
    always_comb begin
        w_tx_d = UART_IDLE_LEVEL;
        case (r_state)
            START:   w_tx_d = 1'b0;
            DATA:    w_tx_d = r_shreg[0];
            default: w_tx_d = UART_IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_bcnt  <= '0;
            r_bidx  <= '0;
            r_shreg <= '0;
            r_tx    <= UART_IDLE_LEVEL;
        end else begin
            r_state <= w_state_d;
            r_bcnt  <= w_bcnt_d;
            r_bidx  <= w_bidx_d;
            r_shreg <= w_shreg_d;
            r_tx    <= w_tx_d;
        end
    end

endmodule

// File: tb/tb_ncsim_uart_injector.sv
// Self-checking bench for ncsim_uart_injector (DIV=8, FIFO depth 4).
// Accepted pushes go into a scoreboard queue; a reference receiver decodes
// uart_tx and compares each frame with the queue head.
module tb_ncsim_uart_injector;

    localparam int unsigned CLK_HZ      = 8000;
    localparam int unsigned UART_CLK_HZ = 1000;
    localparam int unsigned DEPTH       = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       push_valid = 1'b0;
    logic [7:0] push_data = 8'h00;
    logic       flush = 1'b0;
    logic       push_ready;
    logic       uart_tx;
    logic       busy;
    logic [2:0] fifo_count;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         frames = 0;
    logic [7:0] exp_q[$];
    int         starts[$];

    ncsim_uart_injector #(
        .CLK_HZ      (CLK_HZ),
        .UART_CLK_HZ (UART_CLK_HZ),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_push_valid (push_valid),
        .i_push_data  (push_data),
        .o_push_ready (push_ready),
        .i_flush      (flush),
        .o_uart_tx    (uart_tx),
        .o_busy       (busy),
        .o_fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: record every accepted byte (a flush drops the push).
    always @(posedge clk) begin
        if (!rst && !flush && push_valid && push_ready) exp_q.push_back(push_data);
    end

    task automatic rx_wait(input int n, output bit abort);
        abort = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (rst) begin
                abort = 1'b1;
                return;
            end
        end
    endtask

    // Reference receiver: detect start, sample mid-bit, check stop bit.
    initial begin
        bit         ab;
        logic [7:0] rx;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (!rst && uart_tx === 1'b0) begin
                starts.push_back(cyc);
                rx_wait(4, ab);
                if (!ab) begin
                    total++;
                    if (uart_tx !== 1'b0) begin
                        bad++;
                        $display("FAIL rx_start_mid: got %b required 0", uart_tx);
                    end
                end
                for (int b = 0; b < 8 && !ab; b++) begin
                    rx_wait(8, ab);
                    rx[b] = uart_tx;
                end
                if (!ab) rx_wait(8, ab);
                if (!ab) begin
                    total++;
                    if (uart_tx !== 1'b1) begin
                        bad++;
                        $display("FAIL rx_stop: got %b required 1", uart_tx);
                    end
                    frames++;
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL rx_unexpected: got frame %h required none", rx);
                    end else begin
                        e = exp_q.pop_front();
                        if (rx !== e) begin
                            bad++;
                            $display("FAIL rx_data: got %h required %h", rx, e);
                        end
                    end
                end
            end
        end
    end

    // Call at or after a posedge; returns #1 after the accepting edge.
    task automatic push_byte(input logic [7:0] d, output bit ok);
        int guard;
        ok = 1'b1;
        guard = 0;
        push_valid = 1'b1;
        push_data  = d;
        while (!push_ready && guard < 400) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (!push_ready) ok = 1'b0;
        @(posedge clk);
        #1;
        push_valid = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #1 rst = 1'b1;
        #3;
        total += 4;
        if (uart_tx !== 1'b1) begin bad++; $display("FAIL rst_tx: got %b required 1", uart_tx); end
        if (push_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b required 1", push_ready); end
        if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b required 0", busy); end
        if (fifo_count !== 3'd0) begin bad++; $display("FAIL rst_count: got %0d required 0", fifo_count); end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total += 2;
        if (uart_tx !== 1'b1) begin bad++; $display("FAIL post_rst_tx: got %b required 1", uart_tx); end
        if (busy !== 1'b0) begin bad++; $display("FAIL post_rst_busy: got %b required 0", busy); end
    endtask

    task automatic test_single;
        bit         ok;
        int         f0;
        logic [7:0] d;
        logic       exp_tx;
        f0 = frames;
        d  = 8'h55;
        push_byte(d, ok);   // accepted at edge 0
        for (int k = 0; k <= 85; k++) begin
            @(negedge clk); // after edge k
            if (k >= 2 && k <= 9)        exp_tx = 1'b0;
            else if (k >= 10 && k <= 73) exp_tx = d[(k - 10) / 8];
            else                         exp_tx = 1'b1;
            total++;
            if (uart_tx !== exp_tx) begin
                bad++;
                $display("FAIL single_tx cycle %0d: got %b required %b", k, uart_tx, exp_tx);
            end
            if (k == 80 || k == 81) begin
                total++;
                if (busy !== (k == 80)) begin
                    bad++;
                    $display("FAIL single_busy cycle %0d: got %b required %b", k, busy, k == 80);
                end
            end
        end
        wait_idle(ok);
        total += 2;
        if (!ok) begin bad++; $display("FAIL single_idle: got busy required idle"); end
        if (frames - f0 != 1) begin bad++; $display("FAIL single_frames: got %0d required 1", frames - f0); end
    endtask

    task automatic test_back_to_back;
        bit ok;
        int f0;
        f0 = frames;
        starts.delete();
        push_byte(8'hA3, ok);
        push_byte(8'h0F, ok);
        wait_idle(ok);
        total += 3;
        if (frames - f0 != 2) begin bad++; $display("FAIL b2b_frames: got %0d required 2", frames - f0); end
        if (starts.size() != 2) begin
            bad++;
            $display("FAIL b2b_starts: got %0d required 2", starts.size());
        end else if (starts[1] - starts[0] != 80) begin
            bad++;
            $display("FAIL b2b_spacing: got %0d required 80", starts[1] - starts[0]);
        end
        if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_left: got %0d required 0", exp_q.size()); end
    endtask

    task automatic test_push_pop;
        bit ok;
        int f0;
        f0 = frames;
        push_byte(8'h5A, ok);   // count 1
        push_byte(8'hC3, ok);   // FSM pops the same cycle
        total++;
        if (fifo_count !== 3'd1) begin bad++; $display("FAIL pp_count: got %0d required 1", fifo_count); end
        wait_idle(ok);
        total += 2;
        if (frames - f0 != 2) begin bad++; $display("FAIL pp_frames: got %0d required 2", frames - f0); end
        if (exp_q.size() != 0) begin bad++; $display("FAIL pp_left: got %0d required 0", exp_q.size()); end
    endtask

    task automatic test_full;
        bit ok;
        int f0;
        f0 = frames;
        for (int i = 0; i < 5; i++) push_byte(8'hB0 + 8'(i), ok);
        total += 2;
        if (push_ready !== 1'b0) begin bad++; $display("FAIL full_ready: got %b required 0", push_ready); end
        if (fifo_count !== 3'd4) begin bad++; $display("FAIL full_count: got %0d required 4", fifo_count); end
        push_byte(8'hE6, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL full_stall: got timeout required accept"); end
        wait_idle(ok);
        total += 2;
        if (frames - f0 != 6) begin bad++; $display("FAIL full_frames: got %0d required 6", frames - f0); end
        if (exp_q.size() != 0) begin bad++; $display("FAIL full_left: got %0d required 0", exp_q.size()); end
    endtask

    task automatic test_flush;
        bit ok;
        bit high;
        int f0;
        f0 = frames;
        push_byte(8'h11, ok);
        push_byte(8'h22, ok);
        push_byte(8'h33, ok);
        repeat (20) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        while (exp_q.size() > 1) void'(exp_q.pop_back());
        total += 2;
        if (fifo_count !== 3'd0) begin bad++; $display("FAIL flush_count: got %0d required 0", fifo_count); end
        if (busy !== 1'b1) begin bad++; $display("FAIL flush_busy: got %b required 1", busy); end
        wait_idle(ok);
        high = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) high = 1'b0;
        end
        total += 3;
        if (!high) begin bad++; $display("FAIL flush_line: got low required high"); end
        if (frames - f0 != 1) begin bad++; $display("FAIL flush_frames: got %0d required 1", frames - f0); end
        if (exp_q.size() != 0) begin bad++; $display("FAIL flush_left: got %0d required 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid;
        bit ok;
        int f0;
        push_byte(8'hFF, ok);
        push_byte(8'h77, ok);
        repeat (20) @(posedge clk);
        #1;
        total++;
        if (fifo_count !== 3'd1) begin bad++; $display("FAIL rmid_pre_count: got %0d required 1", fifo_count); end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        total += 3;
        if (uart_tx !== 1'b1) begin bad++; $display("FAIL rmid_tx: got %b required 1", uart_tx); end
        if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy: got %b required 0", busy); end
        if (fifo_count !== 3'd0) begin bad++; $display("FAIL rmid_count: got %0d required 0", fifo_count); end
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        f0 = frames;
        push_byte(8'h42, ok);
        wait_idle(ok);
        total += 2;
        if (frames - f0 != 1) begin bad++; $display("FAIL rmid_frames: got %0d required 1", frames - f0); end
        if (exp_q.size() != 0) begin bad++; $display("FAIL rmid_left: got %0d required 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_push_pop();
        test_full();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
